mpsk_diff_codec: RTL and testbench
==================================

Name: mpsk_diff_codec

Overview:
Parametrised differential (absolute-to-relative) encoder and matching relative-to-absolute decoder for M-PSK, where M = 2^K.
- Generalises the fixed 2-bit QPSK code conversion to K bits per symbol, with optional Gray mapping, a valid qualifier, a reference resync, and a phase-rotation injection port that emulates carrier phase ambiguity.
- Sits between the symbol source and the PSK mapper (encoder path), with the decoder chained in loopback for on-chip verification.

Parameters:
K, 2, bits per symbol (legal 1..4); M = 2^K phase states.
GRAY, 1, 1 = ab_in/ab_out are Gray-coded symbol labels; 0 = natural binary.
CW, 16, width of the self-check error counter (used only with the optional feature).

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  asynchronous reset, active-low
in_valid  in  1  ab_in/sync qualifier; one symbol per high cycle
sync  in  1  qualified by in_valid; forces the reference phase to 0 for this symbol
ab_in  in  K  absolute code symbol
rot  in  K  phase rotation (mod M) added to the decoder input, emulating carrier ambiguity
cd  out  K  relative (differential) code, binary phase index
cd_valid  out  1  cd qualifier
ab_out  out  K  recovered absolute code
out_valid  out  1  ab_out qualifier

Behaviour:
- Reset (rst low, async): cd=0, cd_valid=0, ab_out=0, out_valid=0, encoder ref=0, decoder ref=0, internal sync pipe flags=0.
- Arithmetic: all mod M, K-bit wrap, no carry retained.
- Stage 1, encoder:
  - On clk with in_valid=1: a_b = GRAY ? gray2bin(ab_in) : ab_in.
  - cd <= (sync ? 0 : cd_ref) + a_b; cd_ref <= that same value.
  - cd_valid <= in_valid. The sync flag is registered alongside cd.
  - in_valid=0: cd and cd_ref hold; cd_valid=0.
- Stage 2, decoder:
  - On clk with cd_valid=1: r = cd + rot; d = r - (sync_d ? 0 : dec_ref); dec_ref <= r.
  - ab_out <= GRAY ? bin2gray(d) : d; out_valid <= cd_valid.
  - cd_valid=0: ab_out and dec_ref hold; out_valid=0.
- Latency: cd is 1 cycle after in_valid; ab_out is 2 cycles after in_valid. Throughput is 1 symbol/cycle. Gaps in in_valid are transparent.
- With rot constant, ab_out equals ab_in delayed by 2 valid cycles, including the first symbol after reset or sync.
- When rot changes between two consecutive decoded symbols, exactly one ab_out symbol is offset by the rot delta (mod M, in the binary domain); subsequent symbols are correct.
- sync with in_valid=0 is ignored.
- sync on consecutive symbols: every such symbol is encoded as a_b directly.
- Reset mid-stream: the pipeline is flushed and in-flight symbols are lost; the first symbol after reset uses ref 0.
- K=1 degenerates to DBPSK (XOR differential); GRAY is then a no-op.

Optional Feature:
- Macro CODEC_SELFCHECK_EN. When defined, add:
  - Port err_clr (in, 1): synchronous clear of the error counter.
  - Port err_cnt (out, CW): mismatch count.
  - Port err_flag (out, 1): registered, high for one cycle per mismatch.
  - A 2-deep valid-aligned delay of ab_in, compared with ab_out when out_valid=1.
- Each mismatch increments err_cnt, saturating at 2^CW-1.
- err_clr has priority over an increment in the same cycle.
- Reset values: err_cnt=0, err_flag=0.
- Without the macro, none of these ports or registers exist.

Test Plan:
1. K=2, GRAY=0, rot=0, sync on first symbol, ab_in=1,2,3,0 back-to-back -> cd=1,3,2,2; ab_out=1,2,3,0, with each output 2 cycles after its input.
2. K=2, GRAY=1, ab_in=01,11,10,00 with sync on first -> cd=1,3,2,2 (binary); ab_out=01,11,10,00.
3. K=2, GRAY=0, ab_in=1,1,1,1; rot changes 0→1 when the 3rd symbol reaches the decoder -> ab_out=1,1,2,1. With CODEC_SELFCHECK_EN: err_cnt=1, err_flag pulses once.
4. K=3, ab_in=7,7 then 5 with in_valid gaps of 3 cycles -> cd=7,6,3 (wrap mod 8); ab_out=7,7,5; out_valid pulses only on valid symbols.
5. Assert rst low mid-stream, hold 2 cycles -> all outputs 0 immediately. Then ab_in=2,1 without sync -> cd=2,3 and ab_out=2,1.
6. CODEC_SELFCHECK_EN, CW=2, force 5 mismatches via rot toggling -> err_cnt saturates at 3. err_clr coinciding with a mismatch -> err_cnt=0.

Source files
------------

// File: rtl/mpsk_diff_codec.sv
// M-PSK (M = 2^K) differential encoder with a chained differential decoder for loopback.
// Define CODEC_SELFCHECK_EN to add the ab_in-vs-ab_out mismatch counter.
module mpsk_diff_codec #(
  parameter int K    = 2,
  parameter int GRAY = 1,
  parameter int CW   = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic         sync,
  input  logic [K-1:0] ab_in,
  input  logic [K-1:0] rot,
`ifdef CODEC_SELFCHECK_EN
  input  logic          err_clr,
  output logic [CW-1:0] err_cnt,
  output logic          err_flag,
`endif
  output logic [K-1:0] cd,
  output logic         cd_valid,
  output logic [K-1:0] ab_out,
  output logic         out_valid
);

  if (K < 1 || K > 4 || CW < 1) begin : g_param_check
    $error("mpsk_diff_codec: K must be 1..4 and CW at least 1");
  end

  function automatic logic [K-1:0] gray2bin(input logic [K-1:0] g);
    logic [K-1:0] b;
    b[K-1] = g[K-1];
    for (int i = K - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  function automatic logic [K-1:0] bin2gray(input logic [K-1:0] b);
    return b ^ (b >> 1);
  endfunction

  logic [K-1:0] a_b_s;
  logic [K-1:0] enc_sum_s;
  logic [K-1:0] r_s;
  logic [K-1:0] d_s;
  logic [K-1:0] dec_label_s;
  logic         sync_d_r;
  logic [K-1:0] dec_ref_r;

  // Phase arithmetic for both stages; K-bit wrap gives the mod-M behaviour.
  always_comb begin
    a_b_s       = (GRAY != 0) ? gray2bin(ab_in) : ab_in;
    enc_sum_s   = (sync ? {K{1'b0}} : cd) + a_b_s;
    r_s         = cd + rot;
    d_s         = r_s - (sync_d_r ? {K{1'b0}} : dec_ref_r);
    dec_label_s = (GRAY != 0) ? bin2gray(d_s) : d_s;
  end

  // Encoder stage: cd doubles as the encoder reference since both always carry the same value.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cd       <= {K{1'b0}};
      cd_valid <= 1'b0;
      sync_d_r <= 1'b0;
    end else if (in_valid) begin
      cd       <= enc_sum_s;
      cd_valid <= 1'b1;
      sync_d_r <= sync;
    end else begin
      cd_valid <= 1'b0;
    end
  end

  // Decoder stage: the reference is the rotated phase, so a constant rot cancels out.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ab_out    <= {K{1'b0}};
      out_valid <= 1'b0;
      dec_ref_r <= {K{1'b0}};
    end else if (cd_valid) begin
      ab_out    <= dec_label_s;
      out_valid <= 1'b1;
      dec_ref_r <= r_s;
    end else begin
      out_valid <= 1'b0;
    end
  end

`ifdef CODEC_SELFCHECK_EN
  logic [K-1:0] ab_d1_r;
  logic [K-1:0] ab_d2_r;
  logic         mismatch_s;

  assign mismatch_s = out_valid && (ab_out != ab_d2_r);

  // Delay ab_in along the valid pipeline so it lines up with ab_out.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ab_d1_r <= {K{1'b0}};
      ab_d2_r <= {K{1'b0}};
    end else begin
      if (in_valid) begin
        ab_d1_r <= ab_in;
      end else begin
        ab_d1_r <= ab_d1_r;
      end
      if (cd_valid) begin
        ab_d2_r <= ab_d1_r;
      end else begin
        ab_d2_r <= ab_d2_r;
      end
    end
  end

  // Saturating mismatch counter; a clear wins over a same-cycle increment.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_cnt  <= {CW{1'b0}};
      err_flag <= 1'b0;
    end else begin
      err_flag <= mismatch_s;
      if (err_clr) begin
        err_cnt <= {CW{1'b0}};
      end else if (mismatch_s && (err_cnt != {CW{1'b1}})) begin
        err_cnt <= err_cnt + {{(CW-1){1'b0}}, 1'b1};
      end else begin
        err_cnt <= err_cnt;
      end
    end
  end
`endif

endmodule

// File: tb/tb_mpsk_diff_codec.sv
// Table-driven bench for mpsk_diff_codec: three parameter sets, scoreboard queues for cd and ab_out.
module tb_mpsk_diff_codec;

  typedef struct {
    int         inst;
    bit         v;
    bit         s;
    logic [3:0] ab;
    logic [3:0] rot;
    bit         clr;
    logic [3:0] ecd;
    logic [3:0] eab;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       in_valid0 = 1'b0, in_valid1 = 1'b0, in_valid2 = 1'b0;
  logic       sync = 1'b0;
  logic [3:0] ab = 4'd0;
  logic [3:0] rot = 4'd0;
  logic       err_clr = 1'b0;

  logic [1:0] cd0, ab_out0, cd1, ab_out1;
  logic [2:0] cd2, ab_out2;
  logic       cd_valid0, out_valid0, cd_valid1, out_valid1, cd_valid2, out_valid2;
  logic [1:0] err_cnt0;
  logic [15:0] err_cnt1, err_cnt2;
  logic       err_flag0, err_flag1, err_flag2;

  int         n_vec = 0;
  int         n_err = 0;
  int         cur = 0;
  int         flag_pulses = 0;
  logic [3:0] exp_cd_q[$];
  logic [3:0] exp_ab_q[$];
  vec_t       vecs[$];

  logic [3:0] mon_cd, mon_ab;
  logic       mon_cv, mon_ov;

  always #5 clk = ~clk;

  mpsk_diff_codec #(.K(2), .GRAY(0), .CW(2)) u_k2_bin (
    .clk(clk), .rst(rst), .in_valid(in_valid0), .sync(sync), .ab_in(ab[1:0]), .rot(rot[1:0]),
`ifdef CODEC_SELFCHECK_EN
    .err_clr(err_clr), .err_cnt(err_cnt0), .err_flag(err_flag0),
`endif
    .cd(cd0), .cd_valid(cd_valid0), .ab_out(ab_out0), .out_valid(out_valid0));

  mpsk_diff_codec #(.K(2), .GRAY(1), .CW(16)) u_k2_gray (
    .clk(clk), .rst(rst), .in_valid(in_valid1), .sync(sync), .ab_in(ab[1:0]), .rot(rot[1:0]),
`ifdef CODEC_SELFCHECK_EN
    .err_clr(err_clr), .err_cnt(err_cnt1), .err_flag(err_flag1),
`endif
    .cd(cd1), .cd_valid(cd_valid1), .ab_out(ab_out1), .out_valid(out_valid1));

  mpsk_diff_codec #(.K(3), .GRAY(0), .CW(16)) u_k3_bin (
    .clk(clk), .rst(rst), .in_valid(in_valid2), .sync(sync), .ab_in(ab[2:0]), .rot(rot[2:0]),
`ifdef CODEC_SELFCHECK_EN
    .err_clr(err_clr), .err_cnt(err_cnt2), .err_flag(err_flag2),
`endif
    .cd(cd2), .cd_valid(cd_valid2), .ab_out(ab_out2), .out_valid(out_valid2));

`ifndef CODEC_SELFCHECK_EN
  assign err_cnt0 = 2'd0;
  assign err_cnt1 = 16'd0;
  assign err_cnt2 = 16'd0;
  assign err_flag0 = 1'b0;
  assign err_flag1 = 1'b0;
  assign err_flag2 = 1'b0;
`endif

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, expv, $time);
    end
  endtask

  function automatic vec_t mk(input int inst, input bit v, input bit s, input int a, input int r,
                              input bit clr, input int ecd, input int eab);
    vec_t t;
    t.inst = inst; t.v = v; t.s = s; t.ab = 4'(a); t.rot = 4'(r);
    t.clr = clr; t.ecd = 4'(ecd); t.eab = 4'(eab);
    return t;
  endfunction

  task automatic idle(input int inst, input int r, input int n);
    for (int i = 0; i < n; i++) vecs.push_back(mk(inst, 1'b0, 1'b0, 0, r, 1'b0, 0, 0));
  endtask

  task automatic apply(input vec_t v);
    @(posedge clk); #1;
    cur = v.inst;
    in_valid0 = v.v && (v.inst == 0);
    in_valid1 = v.v && (v.inst == 1);
    in_valid2 = v.v && (v.inst == 2);
    sync = v.s; ab = v.ab; rot = v.rot; err_clr = v.clr;
    if (v.v) begin
      exp_cd_q.push_back(v.ecd);
      exp_ab_q.push_back(v.eab);
    end
  endtask

  task automatic run_rows(input int lo, input int hi);
    for (int i = lo; i < hi; i++) apply(vecs[i]);
  endtask

  // Monitor: pop the scoreboard whenever the active instance presents a qualified output.
  always @(negedge clk) begin
    case (cur)
      0: begin mon_cd = {2'b00, cd0}; mon_cv = cd_valid0; mon_ab = {2'b00, ab_out0}; mon_ov = out_valid0; end
      1: begin mon_cd = {2'b00, cd1}; mon_cv = cd_valid1; mon_ab = {2'b00, ab_out1}; mon_ov = out_valid1; end
      default: begin mon_cd = {1'b0, cd2}; mon_cv = cd_valid2; mon_ab = {1'b0, ab_out2}; mon_ov = out_valid2; end
    endcase
    if (err_flag0) flag_pulses++;
    if (mon_cv) begin
      if (exp_cd_q.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL cd_valid: unexpected pulse on instance %0d, cd=%0d (t=%0t)", cur, mon_cd, $time);
      end else begin
        check("cd", {12'd0, mon_cd}, {12'd0, exp_cd_q.pop_front()});
      end
    end
    if (mon_ov) begin
      if (exp_ab_q.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL out_valid: unexpected pulse on instance %0d, ab_out=%0d (t=%0t)", cur, mon_ab, $time);
      end else begin
        check("ab_out", {12'd0, mon_ab}, {12'd0, exp_ab_q.pop_front()});
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    int s_a, s_b, s_c, s_d, s_e, s_f, s_g, s_end;
    int fp0;

    // Test 1: K=2 binary, sync on first symbol
    s_a = vecs.size();
    vecs.push_back(mk(0, 1, 1, 1, 0, 0, 1, 1));
    vecs.push_back(mk(0, 1, 0, 2, 0, 0, 3, 2));
    vecs.push_back(mk(0, 1, 0, 3, 0, 0, 2, 3));
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 2, 0));
    idle(0, 0, 3);
    // Test 2: K=2 Gray labels 01,11,10,00
    s_b = vecs.size();
    vecs.push_back(mk(1, 1, 1, 1, 0, 0, 1, 1));
    vecs.push_back(mk(1, 1, 0, 3, 0, 0, 3, 3));
    vecs.push_back(mk(1, 1, 0, 2, 0, 0, 2, 2));
    vecs.push_back(mk(1, 1, 0, 0, 0, 0, 2, 0));
    idle(1, 0, 3);
    // Test 3: rot steps 0->1 as the third symbol is decoded
    s_c = vecs.size();
    vecs.push_back(mk(0, 1, 1, 1, 0, 0, 1, 1));
    vecs.push_back(mk(0, 1, 0, 1, 0, 0, 2, 1));
    vecs.push_back(mk(0, 1, 0, 1, 0, 0, 3, 2));
    vecs.push_back(mk(0, 1, 0, 1, 1, 0, 0, 1));
    idle(0, 1, 3);
    // Test 6a: clear, then five mismatches from rot toggling
    s_d = vecs.size();
    vecs.push_back(mk(0, 0, 0, 0, 1, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 1, 1, 0, 1, 0));
    vecs.push_back(mk(0, 1, 0, 1, 0, 0, 2, 2));
    vecs.push_back(mk(0, 1, 0, 1, 1, 0, 3, 0));
    vecs.push_back(mk(0, 1, 0, 1, 0, 0, 0, 2));
    vecs.push_back(mk(0, 1, 0, 1, 1, 0, 1, 0));
    vecs.push_back(mk(0, 1, 0, 1, 0, 0, 2, 1));
    idle(0, 0, 3);
    // Test 6b: err_clr lands on the same edge as a mismatch
    s_e = vecs.size();
    vecs.push_back(mk(0, 1, 0, 1, 0, 0, 3, 2));
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0));
    idle(0, 1, 2);
    // Test 4: K=3, wrap mod 8, gaps of 3 idle cycles
    s_f = vecs.size();
    vecs.push_back(mk(2, 1, 0, 7, 0, 0, 7, 7));
    idle(2, 0, 3);
    vecs.push_back(mk(2, 1, 0, 7, 0, 0, 6, 7));
    idle(2, 0, 3);
    vecs.push_back(mk(2, 1, 0, 5, 0, 0, 3, 5));
    idle(2, 0, 3);
    // Test 5 tail: after a mid-stream reset, no sync
    s_g = vecs.size();
    vecs.push_back(mk(0, 1, 0, 2, 0, 0, 2, 2));
    vecs.push_back(mk(0, 1, 0, 1, 0, 0, 3, 1));
    idle(0, 0, 4);
    s_end = vecs.size();

    // Reset values
    #3;
    check("rst_cd0", {14'd0, cd0}, 16'd0);       check("rst_cdv0", {15'd0, cd_valid0}, 16'd0);
    check("rst_ab0", {14'd0, ab_out0}, 16'd0);   check("rst_ov0", {15'd0, out_valid0}, 16'd0);
    check("rst_cd1", {14'd0, cd1}, 16'd0);       check("rst_cdv1", {15'd0, cd_valid1}, 16'd0);
    check("rst_ab1", {14'd0, ab_out1}, 16'd0);   check("rst_ov1", {15'd0, out_valid1}, 16'd0);
    check("rst_cd2", {13'd0, cd2}, 16'd0);       check("rst_cdv2", {15'd0, cd_valid2}, 16'd0);
    check("rst_ab2", {13'd0, ab_out2}, 16'd0);   check("rst_ov2", {15'd0, out_valid2}, 16'd0);
`ifdef CODEC_SELFCHECK_EN
    check("rst_err_cnt", {14'd0, err_cnt0}, 16'd0);
    check("rst_err_flag", {15'd0, err_flag0}, 16'd0);
`endif
    @(posedge clk); #2; rst = 1'b1;

    run_rows(s_a, s_b);
`ifdef CODEC_SELFCHECK_EN
    check("err_cnt_clean", {14'd0, err_cnt0}, 16'd0);
`endif
    run_rows(s_b, s_c);
    fp0 = flag_pulses;
    run_rows(s_c, s_d);
`ifdef CODEC_SELFCHECK_EN
    check("err_cnt_rot_step", {14'd0, err_cnt0}, 16'd1);
    check("err_flag_pulses", 16'(flag_pulses - fp0), 16'd1);
`endif
    run_rows(s_d, s_e);
`ifdef CODEC_SELFCHECK_EN
    check("err_cnt_saturate", {14'd0, err_cnt0}, 16'd3);
`endif
    run_rows(s_e, s_f);
`ifdef CODEC_SELFCHECK_EN
    check("err_clr_priority", {14'd0, err_cnt0}, 16'd0);
`endif
    run_rows(s_f, s_g);

    // Test 5: reset mid-stream with a symbol in flight
    apply(mk(0, 1, 0, 1, 0, 0, 0, 1));
    @(posedge clk); #1;
    in_valid0 = 1'b0;
    #1; rst = 1'b0;
    #1;
    check("midrst_cd", {14'd0, cd0}, 16'd0);
    check("midrst_cdv", {15'd0, cd_valid0}, 16'd0);
    check("midrst_ab", {14'd0, ab_out0}, 16'd0);
    check("midrst_ov", {15'd0, out_valid0}, 16'd0);
    exp_cd_q.delete();
    exp_ab_q.delete();
    @(posedge clk); @(posedge clk); #2; rst = 1'b1;
    run_rows(s_g, s_end);

    check("pending_cd", 16'(exp_cd_q.size()), 16'd0);
    check("pending_ab", 16'(exp_ab_q.size()), 16'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
